// File: rtl/loongarch_pkg.sv
// rtl/loongarch_pkg.sv - shared LoongArch decode constants, bus widths and ID state type
package loongarch_pkg;

  localparam logic [31:0] LA_RESET_PC    = 32'h1c000000;
  localparam int          LA_BUS_IF_ID_W = 65;
  localparam int          LA_BUS_ID_EX_W = 134;

  // Opcode fields, right-aligned to the instruction bits they are compared against
  localparam logic [16:0] OP17_ADD_W  = 17'h00020;  // inst[31:15]
  localparam logic [16:0] OP17_SUB_W  = 17'h00022;  // inst[31:15]
  localparam logic [9:0]  OP10_ADDI_W = 10'h00a;    // inst[31:22]
  localparam logic [9:0]  OP10_LD_W   = 10'h0a2;    // inst[31:22]
  localparam logic [9:0]  OP10_ST_W   = 10'h0a6;    // inst[31:22]
  localparam logic [6:0]  OP7_LU12I_W = 7'h0a;      // inst[31:25]
  localparam logic [5:0]  OP6_JIRL    = 6'h13;      // inst[31:26]
  localparam logic [5:0]  OP6_B       = 6'h14;
  localparam logic [5:0]  OP6_BL      = 6'h15;
  localparam logic [5:0]  OP6_BEQ     = 6'h16;
  localparam logic [5:0]  OP6_BNE     = 6'h17;

  // RUN accepts in order; WAIT discards bundles until fetch delivers the redirect target
  typedef enum logic {
    ID_RUN  = 1'b0,
    ID_WAIT = 1'b1
  } id_state_e;

  // Byte offset of a branch: offs16 alone, or {offs_hi, offs16} for b/bl, shifted by 2 and sign-extended
  function automatic logic [31:0] br_offs_of(input logic [15:0] offs16,
                                             input logic [9:0]  offs_hi,
                                             input logic        is_long);
    logic [31:0] r;
    if (is_long) r = {{4{offs_hi[9]}}, offs_hi, offs16, 2'b00};
    else         r = {{14{offs16[15]}}, offs16, 2'b00};
    return r;
  endfunction

endpackage

// File: rtl/id_decode.sv
// rtl/id_decode.sv - combinational decode of the supported LoongArch subset
module id_decode
  import loongarch_pkg::*;
(
  input  logic [31:0] inst,
  output logic        is_b,
  output logic        is_bl,
  output logic        is_beq,
  output logic        is_bne,
  output logic        is_jirl,
  output logic        use_rj,
  output logic        use_rkd,
  output logic [4:0]  rj_addr,
  output logic [4:0]  rkd_addr,
  output logic [4:0]  dest,
  output logic        gr_we,
  output logic [31:0] br_offs
);

  logic is_add, is_sub, is_addi, is_lu12i, is_ld, is_st;
  logic src2_is_rd;

  // Opcode match; anything unmatched falls through as a nop that writes nothing
  always_comb begin
    is_add   = inst[31:15] == OP17_ADD_W;
    is_sub   = inst[31:15] == OP17_SUB_W;
    is_addi  = inst[31:22] == OP10_ADDI_W;
    is_ld    = inst[31:22] == OP10_LD_W;
    is_st    = inst[31:22] == OP10_ST_W;
    is_lu12i = inst[31:25] == OP7_LU12I_W;
    is_jirl  = inst[31:26] == OP6_JIRL;
    is_b     = inst[31:26] == OP6_B;
    is_bl    = inst[31:26] == OP6_BL;
    is_beq   = inst[31:26] == OP6_BEQ;
    is_bne   = inst[31:26] == OP6_BNE;
  end

  // Source usage, destination and write enable derived from the op flags
  always_comb begin
    src2_is_rd = is_st | is_beq | is_bne;
    use_rj     = is_add | is_sub | is_addi | is_ld | is_st | is_jirl | is_beq | is_bne;
    use_rkd    = is_add | is_sub | src2_is_rd;
    rj_addr    = inst[9:5];
    rkd_addr   = src2_is_rd ? inst[4:0] : inst[14:10];
    gr_we      = is_add | is_sub | is_addi | is_lu12i | is_ld | is_bl | is_jirl;
    if (is_bl)                               dest = 5'd1;
    else if (is_st | is_b | is_beq | is_bne) dest = 5'd0;
    else                                     dest = inst[4:0];
    br_offs    = br_offs_of(inst[25:10], inst[9:0], is_b | is_bl);
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: bundle filtering, branch resolve, replay and issue to EX
module id_stage
  import loongarch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = LA_RESET_PC,
  parameter int          BUS_ID_EX_W = LA_BUS_ID_EX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [64:0]            if_to_id_bus,
  output logic                   id_allowin,
  output logic                   flush,
  output logic [31:0]            pc_real,
  output logic [4:0]             rf_raddr1,
  output logic [4:0]             rf_raddr2,
  input  logic [31:0]            rf_rdata1,
  input  logic [31:0]            rf_rdata2,
  input  logic [4:0]             ex_dest,
  input  logic [4:0]             mem_dest,
  input  logic [4:0]             wb_dest,
  input  logic                   ex_allowin,
  output logic                   id_to_ex_valid,
  output logic [BUS_ID_EX_W-1:0] id_to_ex_bus
);

  logic        in_predict;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  assign {in_predict, in_inst, in_pc} = if_to_id_bus;

  id_state_e   state, state_n;
  logic [31:0] target, target_n;
  logic        valid, redirected, predict_r;
  logic [31:0] pc_r, inst_r;

  logic        is_b, is_bl, is_beq, is_bne, is_jirl;
  logic        use_rj, use_rkd, gr_we;
  logic [4:0]  dest;
  logic [31:0] br_offs;

  id_decode u_decode (
    .inst     (inst_r),
    .is_b     (is_b),
    .is_bl    (is_bl),
    .is_beq   (is_beq),
    .is_bne   (is_bne),
    .is_jirl  (is_jirl),
    .use_rj   (use_rj),
    .use_rkd  (use_rkd),
    .rj_addr  (rf_raddr1),
    .rkd_addr (rf_raddr2),
    .dest     (dest),
    .gr_we    (gr_we),
    .br_offs  (br_offs)
  );

  logic        hazard, readygo, leave;
  logic        taken, br_flush;
  logic [31:0] br_target, br_pc_real;
  logic        in_match, accept, replay;

  // No forwarding: any used nonzero source still pending in EX/MEM/WB holds the op
  always_comb begin
    hazard = (use_rj && rf_raddr1 != 5'd0 &&
              (rf_raddr1 == ex_dest || rf_raddr1 == mem_dest || rf_raddr1 == wb_dest)) ||
             (use_rkd && rf_raddr2 != 5'd0 &&
              (rf_raddr2 == ex_dest || rf_raddr2 == mem_dest || rf_raddr2 == wb_dest));
  end

  assign readygo        = valid & ~hazard;
  assign id_allowin     = ~valid | (readygo & ex_allowin);
  assign id_to_ex_valid = valid & readygo;
  assign leave          = id_to_ex_valid & ex_allowin;
  assign id_to_ex_bus   = {pc_r, inst_r, rf_rdata1, rf_rdata2, dest, gr_we};

  // Branch resolve; redirected keeps a stalled branch from flushing a second time
  always_comb begin
    taken      = is_b | is_bl | is_jirl |
                 (is_beq & (rf_rdata1 == rf_rdata2)) |
                 (is_bne & (rf_rdata1 != rf_rdata2));
    br_target  = (is_jirl ? rf_rdata1 : pc_r) + br_offs;
    br_pc_real = taken ? br_target : pc_r + 32'd4;
    br_flush   = readygo & ~redirected & (taken != predict_r);
  end

  // Next state: branch flush beats replay; a bundle is only considered when it is on-path
  always_comb begin
    in_match = (state == ID_RUN) || (in_pc == target);
    accept   = 1'b0;
    replay   = 1'b0;
    state_n  = state;
    target_n = target;
    if (br_flush) begin
      state_n  = ID_WAIT;
      target_n = br_pc_real;
    end else if (in_match) begin
      if (id_allowin) begin
        accept  = 1'b1;
        state_n = ID_RUN;
      end else begin
        replay   = 1'b1;
        state_n  = ID_WAIT;
        target_n = in_pc;
      end
    end
  end

  // State register; reset waits for the first fetch at RESET_PC
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ID_WAIT;
      target <= RESET_PC;
    end else begin
      state  <= state_n;
      target <= target_n;
    end
  end

  // Stage occupancy and latched bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= 1'b0;
      pc_r      <= 32'd0;
      inst_r    <= 32'd0;
      predict_r <= 1'b0;
    end else begin
      if (accept)     valid <= 1'b1;
      else if (leave) valid <= 1'b0;
      if (accept) begin
        pc_r      <= in_pc;
        inst_r    <= in_inst;
        predict_r <= in_predict;
      end
    end
  end

  // Redirected marks the resident op as already resolved until it leaves
  always_ff @(posedge clk) begin
    if (rst)           redirected <= 1'b0;
    else if (leave)    redirected <= 1'b0;
    else if (br_flush) redirected <= 1'b1;
  end

  // Registered one-cycle redirect pulse to fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      flush   <= 1'b0;
      pc_real <= 32'd0;
    end else begin
      flush <= br_flush | replay;
      if (br_flush)    pc_real <= br_pc_real;
      else if (replay) pc_real <= in_pc;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [64:0]  if_to_id_bus;
  logic         id_allowin;
  logic         flush;
  logic [31:0]  pc_real;
  logic [4:0]   rf_raddr1, rf_raddr2;
  logic [31:0]  rf_rdata1, rf_rdata2;
  logic [4:0]   ex_dest, mem_dest, wb_dest;
  logic         ex_allowin;
  logic         id_to_ex_valid;
  logic [133:0] id_to_ex_bus;

  logic [31:0]  regs [32];
  logic [31:0]  issued [$];
  int           flush_cnt = 0;
  int           total = 0;
  int           bad = 0;

  localparam logic [31:0] NOP = 32'h00100000;

  always #5 clk = ~clk;

  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  id_stage dut (
    .clk            (clk),
    .rst            (rst),
    .if_to_id_bus   (if_to_id_bus),
    .id_allowin     (id_allowin),
    .flush          (flush),
    .pc_real        (pc_real),
    .rf_raddr1      (rf_raddr1),
    .rf_raddr2      (rf_raddr2),
    .rf_rdata1      (rf_rdata1),
    .rf_rdata2      (rf_rdata2),
    .ex_dest        (ex_dest),
    .mem_dest       (mem_dest),
    .wb_dest        (wb_dest),
    .ex_allowin     (ex_allowin),
    .id_to_ex_valid (id_to_ex_valid),
    .id_to_ex_bus   (id_to_ex_bus)
  );

  always @(negedge clk) begin
    if (!rst && flush) flush_cnt++;
    if (!rst && id_to_ex_valid && ex_allowin) issued.push_back(id_to_ex_bus[133:102]);
  end

  function automatic logic [31:0] enc_3r(input logic [16:0] op, input logic [4:0] rk, input logic [4:0] rj, input logic [4:0] rd);
    return {op, rk, rj, rd};
  endfunction

  function automatic logic [31:0] enc_i16(input logic [5:0] op, input logic [15:0] offs, input logic [4:0] rj, input logic [4:0] rd);
    return {op, offs, rj, rd};
  endfunction

  function automatic logic [31:0] enc_b(input logic [25:0] offs);
    return {6'h14, offs[15:0], offs[25:16]};
  endfunction

  task automatic put(input logic [31:0] pc, input logic [31:0] inst, input logic pred, input logic [4:0] ed, input logic ea);
    @(posedge clk); #1;
    if_to_id_bus = {pred, inst, pc};
    ex_dest      = ed;
    ex_allowin   = ea;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if_to_id_bus = {1'b0, NOP, 32'h1bfffffc};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (id_to_ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", id_to_ex_valid); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0h exp=0", flush); end
    total++; if (pc_real !== 32'h0) begin bad++; $display("FAIL reset_pc_real got=%h exp=00000000", pc_real); end
    total++; if (id_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%0h exp=1", id_allowin); end
    put(32'h1c000000, enc_3r(17'h00020, 5'd2, 5'd1, 5'd4), 1'b0, 5'd0, 1'b1);
    total++; if (id_to_ex_valid !== 1'b0) begin bad++; $display("FAIL drop_reset_bundle got=%0h exp=0", id_to_ex_valid); end
    put(32'h1c000004, NOP, 1'b0, 5'd0, 1'b1);
    total++; if (id_to_ex_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%0h exp=1", id_to_ex_valid); end
    total++; if (id_to_ex_bus[133:102] !== 32'h1c000000) begin bad++; $display("FAIL first_pc got=%h exp=1c000000", id_to_ex_bus[133:102]); end
    total++; if (id_to_ex_bus[69:38] !== 32'd5 || id_to_ex_bus[37:6] !== 32'd5) begin bad++; $display("FAIL add_operands got=%h/%h exp=5/5", id_to_ex_bus[69:38], id_to_ex_bus[37:6]); end
    total++; if (id_to_ex_bus[5:0] !== {5'd4, 1'b1}) begin bad++; $display("FAIL add_dest got=%h exp=09", id_to_ex_bus[5:0]); end
    total++; if (flush_cnt !== 0) begin bad++; $display("FAIL startup_flushes got=%0d exp=0", flush_cnt); end
  endtask

  task automatic test_beq_taken;
    put(32'h1c000008, enc_i16(6'h16, 16'd4, 5'd1, 5'd2), 1'b0, 5'd0, 1'b1);
    put(32'h1c00000c, NOP, 1'b0, 5'd0, 1'b1);
    total++; if (id_to_ex_valid !== 1'b1 || id_to_ex_bus[133:102] !== 32'h1c000008) begin bad++; $display("FAIL beq_issue got=%0h pc=%h exp=1 pc=1c000008", id_to_ex_valid, id_to_ex_bus[133:102]); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL beq_flush_early got=%0h exp=0", flush); end
    total++; if (id_to_ex_bus[5:0] !== 6'd0) begin bad++; $display("FAIL beq_dest got=%h exp=00", id_to_ex_bus[5:0]); end
    put(32'h1c000010, NOP, 1'b0, 5'd0, 1'b1);
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL beq_flush got=%0h exp=1", flush); end
    total++; if (pc_real !== 32'h1c000018) begin bad++; $display("FAIL beq_pc_real got=%h exp=1c000018", pc_real); end
    total++; if (id_to_ex_valid !== 1'b0) begin bad++; $display("FAIL beq_drop_0c got=%0h exp=0", id_to_ex_valid); end
    put(32'h1c000018, NOP, 1'b0, 5'd0, 1'b1);
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL beq_flush_pulse got=%0h exp=0", flush); end
    total++; if (id_to_ex_valid !== 1'b0) begin bad++; $display("FAIL beq_drop_10 got=%0h exp=0", id_to_ex_valid); end
    put(32'h1c00001c, NOP, 1'b0, 5'd0, 1'b1);
    total++; if (id_to_ex_valid !== 1'b1 || id_to_ex_bus[133:102] !== 32'h1c000018) begin bad++; $display("FAIL beq_target_op got=%0h pc=%h exp=1 pc=1c000018", id_to_ex_valid, id_to_ex_bus[133:102]); end
  endtask

  task automatic test_bne_not_taken;
    put(32'h1c000020, enc_i16(6'h17, 16'd4, 5'd1, 5'd2), 1'b0, 5'd0, 1'b1);
    put(32'h1c000024, NOP, 1'b0, 5'd0, 1'b1);
    total++; if (id_to_ex_valid !== 1'b1 || id_to_ex_bus[133:102] !== 32'h1c000020) begin bad++; $display("FAIL bne_issue got=%0h pc=%h exp=1 pc=1c000020", id_to_ex_valid, id_to_ex_bus[133:102]); end
    put(32'h1c000028, NOP, 1'b0, 5'd0, 1'b1);
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL bne_no_flush got=%0h exp=0", flush); end
    total++; if (id_to_ex_valid !== 1'b1 || id_to_ex_bus[133:102] !== 32'h1c000024) begin bad++; $display("FAIL bne_next got=%0h pc=%h exp=1 pc=1c000024", id_to_ex_valid, id_to_ex_bus[133:102]); end
  endtask

  task automatic test_raw_replay;
    put(32'h1c00002c, enc_3r(17'h00020, 5'd1, 5'd3, 5'd5), 1'b0, 5'd0, 1'b1);
    put(32'h1c000030, NOP, 1'b0, 5'd3, 1'b1);
    total++; if (id_to_ex_valid !== 1'b0) begin bad++; $display("FAIL raw_stall got=%0h exp=0", id_to_ex_valid); end
    total++; if (id_allowin !== 1'b0) begin bad++; $display("FAIL raw_allowin got=%0h exp=0", id_allowin); end
    put(32'h1c000034, NOP, 1'b0, 5'd3, 1'b1);
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL raw_replay_flush got=%0h exp=1", flush); end
    total++; if (pc_real !== 32'h1c000030) begin bad++; $display("FAIL raw_replay_pc got=%h exp=1c000030", pc_real); end
    total++; if (id_to_ex_valid !== 1'b0) begin bad++; $display("FAIL raw_still_stall got=%0h exp=0", id_to_ex_valid); end
    put(32'h1c000030, NOP, 1'b0, 5'd0, 1'b1);
    total++; if (id_to_ex_valid !== 1'b1 || id_to_ex_bus[133:102] !== 32'h1c00002c) begin bad++; $display("FAIL raw_release got=%0h pc=%h exp=1 pc=1c00002c", id_to_ex_valid, id_to_ex_bus[133:102]); end
    total++; if (id_to_ex_bus[69:38] !== 32'd7 || id_to_ex_bus[37:6] !== 32'd5) begin bad++; $display("FAIL raw_operands got=%h/%h exp=7/5", id_to_ex_bus[69:38], id_to_ex_bus[37:6]); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL raw_flush_pulse got=%0h exp=0", flush); end
    put(32'h1c000034, NOP, 1'b0, 5'd0, 1'b1);
    total++; if (id_to_ex_valid !== 1'b1 || id_to_ex_bus[133:102] !== 32'h1c000030) begin bad++; $display("FAIL raw_replayed got=%0h pc=%h exp=1 pc=1c000030", id_to_ex_valid, id_to_ex_bus[133:102]); end
  endtask

  task automatic test_branch_hold;
    int f0;
    put(32'h1c000038, enc_b(26'h10), 1'b0, 5'd0, 1'b1);
    f0 = flush_cnt;
    put(32'h1c00003c, NOP, 1'b0, 5'd0, 1'b0);
    total++; if (id_to_ex_valid !== 1'b1 || id_allowin !== 1'b0) begin bad++; $display("FAIL hold_ready got=%0h/%0h exp=1/0", id_to_ex_valid, id_allowin); end
    // fetch is still on the sequential path while EX is blocked
    put(32'h1c000040, NOP, 1'b0, 5'd0, 1'b0);
    total++; if (flush !== 1'b1 || pc_real !== 32'h1c000078) begin bad++; $display("FAIL hold_flush got=%0h pc=%h exp=1 pc=1c000078", flush, pc_real); end
    put(32'h1c000044, NOP, 1'b0, 5'd0, 1'b0);
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL hold_reflush got=%0h exp=0", flush); end
    put(32'h1c000078, NOP, 1'b0, 5'd0, 1'b1);
    total++; if (id_to_ex_valid !== 1'b1 || id_to_ex_bus[133:102] !== 32'h1c000038) begin bad++; $display("FAIL hold_release got=%0h pc=%h exp=1 pc=1c000038", id_to_ex_valid, id_to_ex_bus[133:102]); end
    put(32'h1c00007c, NOP, 1'b0, 5'd0, 1'b1);
    total++; if (id_to_ex_valid !== 1'b1 || id_to_ex_bus[133:102] !== 32'h1c000078) begin bad++; $display("FAIL hold_target_op got=%0h pc=%h exp=1 pc=1c000078", id_to_ex_valid, id_to_ex_bus[133:102]); end
    total++; if (flush_cnt - f0 !== 1) begin bad++; $display("FAIL hold_flush_count got=%0d exp=1", flush_cnt - f0); end
  endtask

  task automatic test_jirl_reset;
    regs[1] = 32'h1c000100;
    put(32'h1c000080, enc_i16(6'h13, 16'd2, 5'd1, 5'd6), 1'b0, 5'd0, 1'b1);
    put(32'h1c000084, NOP, 1'b0, 5'd0, 1'b1);
    total++; if (id_to_ex_bus[69:38] !== 32'h1c000100) begin bad++; $display("FAIL jirl_rj got=%h exp=1c000100", id_to_ex_bus[69:38]); end
    total++; if (id_to_ex_bus[5:0] !== {5'd6, 1'b1}) begin bad++; $display("FAIL jirl_dest got=%h exp=0d", id_to_ex_bus[5:0]); end
    put(32'h1c000088, NOP, 1'b0, 5'd0, 1'b1);
    total++; if (flush !== 1'b1 || pc_real !== 32'h1c000108) begin bad++; $display("FAIL jirl_flush got=%0h pc=%h exp=1 pc=1c000108", flush, pc_real); end
    @(posedge clk); #1;
    rst = 1'b1;
    if_to_id_bus = {1'b0, NOP, 32'h1c000108};
    @(posedge clk); #1;
    rst = 1'b0;
    if_to_id_bus = {1'b0, NOP, 32'h1c00010c};
    @(negedge clk);
    total++; if (flush !== 1'b0 || pc_real !== 32'h0) begin bad++; $display("FAIL wait_reset_flush got=%0h pc=%h exp=0 pc=00000000", flush, pc_real); end
    total++; if (id_to_ex_valid !== 1'b0) begin bad++; $display("FAIL wait_reset_valid got=%0h exp=0", id_to_ex_valid); end
    put(32'h1c000108, NOP, 1'b0, 5'd0, 1'b1);
    put(32'h1c000000, NOP, 1'b0, 5'd0, 1'b1);
    total++; if (id_to_ex_valid !== 1'b0) begin bad++; $display("FAIL wait_reset_old_target got=%0h exp=0", id_to_ex_valid); end
    put(32'h1c000004, NOP, 1'b0, 5'd0, 1'b1);
    total++; if (id_to_ex_valid !== 1'b1 || id_to_ex_bus[133:102] !== 32'h1c000000) begin bad++; $display("FAIL wait_reset_restart got=%0h pc=%h exp=1 pc=1c000000", id_to_ex_valid, id_to_ex_bus[133:102]); end
  endtask

  task automatic test_issue_order;
    logic [31:0] exp_pc [16];
    exp_pc = '{32'h1c000000, 32'h1c000004, 32'h1c000008, 32'h1c000018,
               32'h1c00001c, 32'h1c000020, 32'h1c000024, 32'h1c000028,
               32'h1c00002c, 32'h1c000030, 32'h1c000034, 32'h1c000038,
               32'h1c000078, 32'h1c00007c, 32'h1c000080, 32'h1c000000};
    @(posedge clk); #1;
    total++; if (issued.size() !== 16) begin bad++; $display("FAIL issue_count got=%0d exp=16", issued.size()); end
    for (int i = 0; i < 16 && i < issued.size(); i++) begin
      total++; if (issued[i] !== exp_pc[i]) begin bad++; $display("FAIL issue_order[%0d] got=%h exp=%h", i, issued[i], exp_pc[i]); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[1] = 32'd5;
    regs[2] = 32'd5;
    regs[3] = 32'd7;
    ex_dest    = 5'd0;
    mem_dest   = 5'd0;
    wb_dest    = 5'd0;
    ex_allowin = 1'b1;
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_raw_replay();
    test_branch_hold();
    test_jirl_reset();
    test_issue_order();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
